// File: rtl/muldiv_pkg.sv
// Shared encodings and the conditional-negate helper for the multiply/divide unit.
package muldiv_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // Two's-complement negate when neg is set; callers zero-extend and keep the low bits.
    function automatic logic [MAX_W-1:0] neg_if(input logic [MAX_W-1:0] v, input logic neg);
        return neg ? (~v + {{(MAX_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Define MULDIV_EARLY_EXIT_EN to let multiplies leave CALC once the remaining multiplier bits are zero.
module mult_div_unit #(
    parameter int NBITS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [NBITS-1:0] operando_A,
    input  logic [NBITS-1:0] operando_B,
    input  logic             flush,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [NBITS-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [NBITS-1:0] hi,
    output logic [NBITS-1:0] lo
);
    import muldiv_pkg::*;

    localparam int              CW       = $clog2(NBITS);
    localparam logic [CW-1:0]   LAST_CNT = CW'(NBITS - 1);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [2*NBITS-1:0]   acc_q, acc_d;
    logic [2*NBITS-1:0]   mcand_q, mcand_d;
    logic [NBITS-1:0]     mplier_q, mplier_d;
    logic [NBITS-1:0]     hi_q, hi_d;
    logic [NBITS-1:0]     lo_q, lo_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic                 in_signed;
    logic                 in_is_div;
    logic [MAX_W-1:0]     abs_a_w, abs_b_w, prod_w, quot_w, rem_w;
    logic                 unused_ext;
    logic [2*NBITS-1:0]   mul_sum;
    logic [NBITS:0]       div_trial;
    logic                 calc_last;

    assign in_signed = ~op[0];
    assign in_is_div = op[1];

    assign abs_a_w = neg_if(MAX_W'(operando_A), in_signed & operando_A[NBITS-1]);
    assign abs_b_w = neg_if(MAX_W'(operando_B), in_signed & operando_B[NBITS-1]);
    assign prod_w  = neg_if(MAX_W'(acc_q), neg_res_q);
    assign quot_w  = neg_if(MAX_W'(acc_q[NBITS-1:0]), neg_res_q);
    assign rem_w   = neg_if(MAX_W'(acc_q[2*NBITS-1:NBITS]), neg_rem_q);
    assign unused_ext = ^{abs_a_w, abs_b_w, prod_w, quot_w, rem_w};

    // Divide keeps {remainder, quotient} in acc; the trial subtract sees the next dividend bit shifted in.
    assign mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign div_trial = acc_q[2*NBITS-1:NBITS-1] - {1'b0, mplier_q};

`ifdef MULDIV_EARLY_EXIT_EN
    assign calc_last = (count_q == LAST_CNT) || (!op_q[1] && (mplier_q[NBITS-1:1] == '0));
`else
    assign calc_last = (count_q == LAST_CNT);
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        count_d   = count_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr_hi) hi_d = wr_data;
                if (wr_lo) lo_d = wr_data;
                if (start && !flush) begin
                    op_d      = op_e'(op);
                    mplier_d  = abs_b_w[NBITS-1:0];
                    mcand_d   = {{NBITS{1'b0}}, abs_a_w[NBITS-1:0]};
                    acc_d     = in_is_div ? {{NBITS{1'b0}}, abs_a_w[NBITS-1:0]} : '0;
                    neg_res_d = in_signed & (operando_A[NBITS-1] ^ operando_B[NBITS-1]);
                    neg_rem_d = in_signed & in_is_div & operando_A[NBITS-1];
                    count_d   = '0;
                    busy_d    = 1'b1;
                    if (in_is_div && (operando_B == '0)) begin
                        acc_d     = {operando_A, {NBITS{1'b1}}};
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        dbz_d     = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    count_d = count_q + CW'(1);
                    if (op_q[1]) begin
                        if (!div_trial[NBITS]) acc_d = {div_trial[NBITS-1:0], acc_q[NBITS-2:0], 1'b1};
                        else                   acc_d = {acc_q[2*NBITS-2:0], 1'b0};
                    end else begin
                        acc_d    = mul_sum;
                        mplier_d = mplier_q >> 1;
                        mcand_d  = mcand_q << 1;
                    end
                    if (calc_last) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d   = op_q[1] ? {rem_w[NBITS-1:0], quot_w[NBITS-1:0]} : prod_w[2*NBITS-1:0];
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                hi_d    = acc_q[2*NBITS-1:NBITS];
                lo_d    = acc_q[NBITS-1:0];
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MULT;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            count_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            count_q   <= count_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
